execution_stage: RTL and testbench
==================================

// Module: execution_stage
// PURPOSE
//  MIPS EX stage: consumes forward_a/forward_b from forwarding_unit and the ID/EX latch.
//  Selects bypassed operands, runs the ALU, and registers the EX/MEM latch (_3_4 outputs).
//  Those outputs feed the MEM stage and return to forwarding_unit as rd_3_4/register_write_3_4.
// PARAMETERS
//  lenghtIN  32  datapath width
//  NB        5   register-address width, $clog2(lenghtIN)
// PORTS
//  CLK100MHZ           in   1         system clock, single clock domain
//  reset               in   1         synchronous, active-high
//  enable              in   1         pipeline advance; 0 = hold all state (debug step)
//  forward_a           in   2         rs select: 00 ID/EX, 01 EX/MEM, 10 MEM/WB
//  forward_b           in   2         rt select, same encoding
//  rs_data_2_3         in   lenghtIN  rs value from ID/EX
//  rt_data_2_3         in   lenghtIN  rt value from ID/EX
//  immediate_2_3       in   lenghtIN  sign-extended immediate
//  shamt_2_3           in   5         shift amount
//  alu_op_2_3          in   4         ALU opcode (shared header)
//  alu_src_2_3         in   1         1 = operand B is immediate
//  reg_dst_2_3         in   1         1 = dest rd, 0 = dest rt
//  rt_2_3, rd_2_3      in   NB        register addresses
//  register_write_2_3, mem_read_2_3, mem_write_2_3, mem_to_reg_2_3  in 1 each  controls
//  write_data_4_5      in   lenghtIN  MEM/WB writeback value (bypass source 10)
//  alu_result_3_4      out  lenghtIN  EX/MEM result; also internal bypass source 01
//  rt_data_3_4         out  lenghtIN  forwarded rt value (store data)
//  rd_3_4              out  NB        destination register
//  register_write_3_4, mem_read_3_4, mem_write_3_4, mem_to_reg_3_4  out 1 each
//  stall_ex            out  1         combinational; 1 = upstream holds PC, IF/ID, ID/EX
// BEHAVIOUR
//  Reset: all _3_4 outputs 0; FSM IDLE; counter 0. Reset beats enable and aborts MUL.
//  Operand A = mux(forward_a). Operand B = alu_src ? immediate : mux(forward_b).
//  Select 11 behaves as 00. rt_data_3_4 always takes the forwarded rt, never the immediate.
//  Ops: ADD/SUB wrap mod 2^lenghtIN, no overflow trap; AND OR XOR NOR.
//  SLT is a signed compare. SLL/SRL/SRA shift B by shamt. LUI = B<<16.
//  Undefined opcodes give result 0; controls still pass through.
//  Latency: one edge per op when enable=1 and stall_ex=0.
//  enable=0: every register and the FSM hold; stall_ex still reflects state.
//  MUL FSM (EX_MULT_EN only): states IDLE, BUSY.
//   IDLE & MUL & enable: capture A/B, counter<=0, go BUSY; stall_ex=1.
//   BUSY: one shift-add step per edge; counter runs 0..lenghtIN-1.
//   stall_ex=1 while counter != lenghtIN-1.
//   Last BUSY cycle: stall_ex=0; the edge writes the low lenghtIN product bits and dest/controls into EX/MEM; go IDLE.
//   Every stalled edge loads a bubble into EX/MEM: all controls 0, rd 0, data 0.
//   Operands are captured at start, so bubbles never corrupt the bypass.
//   Result reaches alu_result_3_4 lenghtIN+1 edges after MUL enters EX.
//   Back-to-back MUL: IDLE is re-entered and the next MUL starts on the following cycle.
// CONFIGURATION
//  EX_MULT_EN defined: iterative multiplier and FSM present, behaviour as above.
//  EX_MULT_EN undefined: no FSM; stall_ex tied 0.
//   MUL is a 1-cycle op with result 0; controls still pass through.
// STRUCTURE
//  Shared header mips_defs.vh: ALU opcode localparams (ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOR=5
//   SLT=6 SLL=7 SRL=8 SRA=9 LUI=10 MUL=11) and FWD_IDEX/FWD_EXMEM/FWD_MEMWB encodings.
//  Sub-module ex_multiplier: shift-add datapath plus counter, start/done handshake.
//   Instantiated under EX_MULT_EN only.
//  ALU, operand muxes and EX/MEM register stay inline.
// TESTING
//  1. reset=1 two edges with random inputs -> all _3_4 outputs 0, stall_ex 0.
//  2. ADD rs=5 rt=7 fwd 00/00 reg_dst=1 rd=3 regwrite=1 -> next edge result 12, rd_3_4 3, regwrite 1.
//  3. Back-to-back dependent ADDs, 2nd fwd_a=01 -> uses 12 to give 12+1=13.
//     fwd_b=10 with write_data_4_5=0xFFFFFFFF -> SUB yields A+1.
//  4. SLT A=-1 B=1 -> 1; SRA 0x80000000 shamt 4 -> 0xF8000000.
//     ADD 0x7FFFFFFF+1 -> 0x80000000, no trap.
//  5. EX_MULT_EN: MUL 6*7 -> stall_ex high 32 cycles, 32 bubble edges, then result 42.
//     MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE. Reset at counter 10 -> IDLE, outputs 0.
//  6. enable=0 mid-MUL for 5 cycles -> counter and outputs frozen, total latency +5.
//     Without EX_MULT_EN, MUL -> result 0 after 1 edge, stall_ex never 1.

Source files
------------

// File: rtl/execution_stage_pkg.sv
// execution_stage_pkg: ALU opcodes, bypass select encodings and the multiplier FSM state type
package execution_stage_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;
    localparam logic [3:0] ALU_MUL = 4'd11;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_t;

endpackage

// File: rtl/execution_stage_multiplier.sv
// ex_multiplier: iterative shift-add multiplier, one partial product per enabled edge.
// start is sampled in IDLE; done marks the final BUSY cycle, when product is the full low-W result.
module ex_multiplier
    import execution_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);
    localparam int CW = $clog2(W);

    mul_state_t    state;
    logic [W-1:0]  ma, mb, acc;
    logic [CW-1:0] count;

    assign busy    = state == MUL_BUSY;
    assign done    = busy && count == CW'(W - 1);
    // product already includes the step taken on the current edge
    assign product = acc + (mb[0] ? ma : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MUL_IDLE;
            count <= '0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
        end else if (enable) begin
            if (state == MUL_IDLE) begin
                if (start) begin
                    state <= MUL_BUSY;
                    ma    <= a;
                    mb    <= b;
                    acc   <= '0;
                    count <= '0;
                end
            end else begin
                acc   <= product;
                ma    <= ma << 1;
                mb    <= mb >> 1;
                count <= count + 1'b1;
                if (done) state <= MUL_IDLE;
            end
        end
    end

endmodule

// File: rtl/execution_stage.sv
// execution_stage: MIPS EX stage -- operand bypass, ALU and EX/MEM latch.
// Define EX_MULT_EN to add the iterative multiplier and its pipeline stall.
module execution_stage
    import execution_stage_pkg::*;
#(
    parameter int lenghtIN = 32,
    parameter int NB       = $clog2(lenghtIN)
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          forward_a,
    input  logic [1:0]          forward_b,
    input  logic [lenghtIN-1:0] rs_data_2_3,
    input  logic [lenghtIN-1:0] rt_data_2_3,
    input  logic [lenghtIN-1:0] immediate_2_3,
    input  logic [4:0]          shamt_2_3,
    input  logic [3:0]          alu_op_2_3,
    input  logic                alu_src_2_3,
    input  logic                reg_dst_2_3,
    input  logic [NB-1:0]       rt_2_3,
    input  logic [NB-1:0]       rd_2_3,
    input  logic                register_write_2_3,
    input  logic                mem_read_2_3,
    input  logic                mem_write_2_3,
    input  logic                mem_to_reg_2_3,
    input  logic [lenghtIN-1:0] write_data_4_5,
    output logic [lenghtIN-1:0] alu_result_3_4,
    output logic [lenghtIN-1:0] rt_data_3_4,
    output logic [NB-1:0]       rd_3_4,
    output logic                register_write_3_4,
    output logic                mem_read_3_4,
    output logic                mem_write_3_4,
    output logic                mem_to_reg_3_4,
    output logic                stall_ex
);
    logic [lenghtIN-1:0] op_a, fwd_b, op_b, alu_out, result;
    logic [NB-1:0]       dest;

    // select 11 is unused by the forwarding unit and falls back to the ID/EX value
    assign op_a = forward_a == FWD_EXMEM ? alu_result_3_4 :
                  forward_a == FWD_MEMWB ? write_data_4_5 : rs_data_2_3;
    assign fwd_b = forward_b == FWD_EXMEM ? alu_result_3_4 :
                   forward_b == FWD_MEMWB ? write_data_4_5 : rt_data_2_3;
    assign op_b = alu_src_2_3 ? immediate_2_3 : fwd_b;
    assign dest = reg_dst_2_3 ? rd_2_3 : rt_2_3;

    always_comb begin
        case (alu_op_2_3)
            ALU_ADD: alu_out = op_a + op_b;
            ALU_SUB: alu_out = op_a - op_b;
            ALU_AND: alu_out = op_a & op_b;
            ALU_OR:  alu_out = op_a | op_b;
            ALU_XOR: alu_out = op_a ^ op_b;
            ALU_NOR: alu_out = ~(op_a | op_b);
            ALU_SLT: alu_out = {{(lenghtIN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLL: alu_out = op_b << shamt_2_3;
            ALU_SRL: alu_out = op_b >> shamt_2_3;
            ALU_SRA: alu_out = $signed(op_b) >>> shamt_2_3;
            ALU_LUI: alu_out = op_b << 16;
            default: alu_out = '0;
        endcase
    end

`ifdef EX_MULT_EN
    logic                is_mul, mul_busy, mul_done;
    logic [lenghtIN-1:0] product;

    assign is_mul = alu_op_2_3 == ALU_MUL;

    ex_multiplier #(.W(lenghtIN)) u_mul (
        .clk     (CLK100MHZ),
        .rst     (reset),
        .enable  (enable),
        .start   (is_mul),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // ID/EX is held during BUSY, so the MUL stays presented until done
    assign stall_ex = mul_busy ? !mul_done : is_mul;
    assign result   = is_mul ? product : alu_out;
`else
    assign stall_ex = 1'b0;
    assign result   = alu_out;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            alu_result_3_4     <= '0;
            rt_data_3_4        <= '0;
            rd_3_4             <= '0;
            register_write_3_4 <= 1'b0;
            mem_read_3_4       <= 1'b0;
            mem_write_3_4      <= 1'b0;
            mem_to_reg_3_4     <= 1'b0;
        end else if (enable) begin
            alu_result_3_4     <= stall_ex ? '0 : result;
            rt_data_3_4        <= stall_ex ? '0 : fwd_b;
            rd_3_4             <= stall_ex ? '0 : dest;
            register_write_3_4 <= !stall_ex && register_write_2_3;
            mem_read_3_4       <= !stall_ex && mem_read_2_3;
            mem_write_3_4      <= !stall_ex && mem_write_2_3;
            mem_to_reg_3_4     <= !stall_ex && mem_to_reg_2_3;
        end
    end

endmodule

// File: tb/tb_execution_stage.sv
// tb_execution_stage: scoreboard bench for the EX stage; multiplier scenarios follow EX_MULT_EN.
module tb_execution_stage;
    import execution_stage_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rtd;
        logic [4:0]  rd;
        logic [3:0]  ctl;
    } exp_t;

    logic        clk = 0;
    logic        reset, enable, alu_src, reg_dst;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] rs_data, rt_data, immediate, write_data;
    logic [4:0]  shamt, rt_addr, rd_addr;
    logic [3:0]  alu_op, ctl;
    logic [31:0] alu_result_3_4, rt_data_3_4;
    logic [4:0]  rd_3_4;
    logic        register_write_3_4, mem_read_3_4, mem_write_3_4, mem_to_reg_3_4, stall_ex;

    exp_t        q[$];
    exp_t        obs;
    logic [31:0] last_res;
    int          checks = 0;
    int          errors = 0;

    assign obs = {alu_result_3_4, rt_data_3_4, rd_3_4,
                  register_write_3_4, mem_read_3_4, mem_write_3_4, mem_to_reg_3_4};

    always #5 clk = ~clk;

    execution_stage dut (
        .CLK100MHZ          (clk),
        .reset              (reset),
        .enable             (enable),
        .forward_a          (forward_a),
        .forward_b          (forward_b),
        .rs_data_2_3        (rs_data),
        .rt_data_2_3        (rt_data),
        .immediate_2_3      (immediate),
        .shamt_2_3          (shamt),
        .alu_op_2_3         (alu_op),
        .alu_src_2_3        (alu_src),
        .reg_dst_2_3        (reg_dst),
        .rt_2_3             (rt_addr),
        .rd_2_3             (rd_addr),
        .register_write_2_3 (ctl[3]),
        .mem_read_2_3       (ctl[2]),
        .mem_write_2_3      (ctl[1]),
        .mem_to_reg_2_3     (ctl[0]),
        .write_data_4_5     (write_data),
        .alu_result_3_4     (alu_result_3_4),
        .rt_data_3_4        (rt_data_3_4),
        .rd_3_4             (rd_3_4),
        .register_write_3_4 (register_write_3_4),
        .mem_read_3_4       (mem_read_3_4),
        .mem_write_3_4      (mem_write_3_4),
        .mem_to_reg_3_4     (mem_to_reg_3_4),
        .stall_ex           (stall_ex)
    );

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [4:0] sh);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~(a | b);
            6:  return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            7:  return b << sh;
            8:  return b >> sh;
            9:  return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            10: return {b[15:0], 16'h0000};
`ifdef EX_MULT_EN
            11: return a * b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] idex);
        return f == 2'b01 ? last_res : f == 2'b10 ? write_data : idex;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [1:0] fa, fb,
                         input logic [31:0] rs, rt, imm, input logic [4:0] sh,
                         input logic src, dst, input logic [4:0] rta, rda,
                         input logic [3:0] c, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] a, bf;
        alu_op = op; forward_a = fa; forward_b = fb; rs_data = rs; rt_data = rt;
        immediate = imm; shamt = sh; alu_src = src; reg_dst = dst;
        rt_addr = rta; rd_addr = rda; ctl = c; write_data = wd;
        a  = pick(fa, rs);
        bf = pick(fb, rt);
        e.res = model(op, a, src ? imm : bf, sh);
        e.rtd = bf;
        e.rd  = dst ? rda : rta;
        e.ctl = c;
        q.push_back(e);
    endtask

    task automatic step(input string name);
        exp_t e;
        @(negedge clk);
        checks++;
        if (stall_ex !== 1'b0) begin
            errors++;
            $display("FAIL %s stall_ex got %b want 0", name, stall_ex);
        end
        @(posedge clk); #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty, got %h", name, obs);
        end else begin
            e = q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL %s got res=%h rtd=%h rd=%0d ctl=%b want res=%h rtd=%h rd=%0d ctl=%b",
                         name, obs.res, obs.rtd, obs.rd, obs.ctl, e.res, e.rtd, e.rd, e.ctl);
            end
            last_res = e.res;
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) begin
            enable = 1'($urandom); forward_a = 2'($urandom); forward_b = 2'($urandom);
            rs_data = $urandom; rt_data = $urandom; immediate = $urandom; write_data = $urandom;
            shamt = 5'($urandom); alu_op = 4'($urandom_range(0, 10)); alu_src = 1'($urandom);
            reg_dst = 1'($urandom); rt_addr = 5'($urandom); rd_addr = 5'($urandom); ctl = 4'($urandom);
            @(posedge clk); #1;
        end
        checks++;
        if (obs !== '0 || stall_ex !== 1'b0) begin
            errors++;
            $display("FAIL reset got outputs=%h stall=%b want 0", obs, stall_ex);
        end
        reset = 0; enable = 1; last_res = 0;
    endtask

    task automatic test_add();
        issue(ALU_ADD, 2'b00, 2'b00, 5, 7, 0, 0, 0, 1, 9, 3, 4'b1000, 0);
        step("add_basic");
    endtask

    task automatic test_forwarding();
        issue(ALU_ADD, 2'b01, 2'b00, 99, 55, 1, 0, 1, 1, 9, 4, 4'b1000, 0);
        step("fwd_exmem_a");
        issue(ALU_SUB, 2'b01, 2'b10, 77, 66, 0, 0, 0, 0, 6, 4, 4'b1000, 32'hFFFF_FFFF);
        step("fwd_memwb_b");
        issue(ALU_ADD, 2'b11, 2'b11, 10, 20, 0, 0, 0, 1, 1, 2, 4'b0000, 32'h1234);
        step("fwd_sel11");
        issue(ALU_ADD, 2'b00, 2'b00, 32'h100, 32'hABCD, 32'h8, 0, 1, 0, 17, 2, 4'b0010, 0);
        step("store_rt_not_imm");
    endtask

    task automatic test_ops();
        issue(ALU_SLT, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0, 5, 4'b1000, 0);
        step("slt_signed");
        issue(ALU_SLT, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 5, 4'b1000, 0);
        step("slt_false");
        issue(ALU_SRA, 0, 0, 0, 32'h8000_0000, 0, 4, 0, 1, 0, 6, 4'b1000, 0);
        step("sra");
        issue(ALU_ADD, 0, 0, 32'h7FFF_FFFF, 1, 0, 0, 0, 1, 0, 7, 4'b1000, 0);
        step("add_overflow");
        issue(ALU_AND, 0, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 0, 1, 0, 8, 4'b1000, 0);
        step("and");
        issue(ALU_OR, 0, 0, 32'hF000_0001, 32'h0000_1000, 0, 0, 0, 1, 0, 8, 4'b1000, 0);
        step("or");
        issue(ALU_XOR, 0, 0, 32'hAAAA_5555, 32'hFFFF_0000, 0, 0, 0, 1, 0, 8, 4'b1000, 0);
        step("xor");
        issue(ALU_NOR, 0, 0, 32'h0000_00F0, 32'h0000_000F, 0, 0, 0, 1, 0, 8, 4'b1000, 0);
        step("nor");
        issue(ALU_SLL, 0, 0, 0, 32'h0000_0003, 0, 31, 0, 1, 0, 9, 4'b1000, 0);
        step("sll");
        issue(ALU_SRL, 0, 0, 0, 32'h8000_0000, 0, 4, 0, 1, 0, 9, 4'b1000, 0);
        step("srl");
        issue(ALU_LUI, 0, 0, 0, 0, 32'h0000_BEEF, 0, 1, 0, 10, 9, 4'b1000, 0);
        step("lui");
        issue(ALU_SUB, 0, 0, 0, 1, 0, 0, 0, 1, 0, 11, 4'b0101, 0);
        step("sub_wrap");
        issue(4'd13, 0, 0, 32'h55, 32'h66, 0, 0, 0, 1, 0, 12, 4'b1111, 0);
        step("undefined_op");
        for (int i = 0; i < 4; i++) begin
            issue(4'($urandom_range(0, 10)), 2'($urandom), 2'($urandom), $urandom, $urandom,
                  $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                  5'($urandom), 4'($urandom), $urandom);
            step("random_op");
        end
    endtask

`ifdef EX_MULT_EN
    task automatic run_mul(input string name, input int freeze_at, input int want_edges);
        int n = 0;
        int edges = 0;
        @(negedge clk);
        while (stall_ex === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            edges++; n++;
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL %s bubble %0d got %h want 0", name, n, obs);
            end
            if (n == freeze_at) begin
                enable = 0;
                repeat (5) begin @(posedge clk); #1; edges++; end
                checks++;
                if (obs !== '0 || stall_ex !== 1'b1) begin
                    errors++;
                    $display("FAIL %s frozen got %h stall=%b want 0 stall=1", name, obs, stall_ex);
                end
                enable = 1;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL %s stalled edges got %0d want 32", name, n);
        end
        step(name);
        edges++;
        checks++;
        if (edges != want_edges) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, edges, want_edges);
        end
    endtask

    task automatic test_mul();
        issue(ALU_MUL, 0, 0, 6, 7, 0, 0, 0, 1, 0, 13, 4'b1000, 0);
        run_mul("mul_6x7", 0, 33);
        issue(ALU_MUL, 0, 0, 32'hFFFF_FFFF, 2, 0, 0, 0, 1, 0, 14, 4'b1000, 0);
        run_mul("mul_wrap", 0, 33);
        issue(ALU_MUL, 0, 0, 32'h1234, 32'h10001, 0, 0, 0, 1, 0, 15, 4'b1001, 0);
        run_mul("mul_freeze", 10, 38);
        issue(ALU_MUL, 0, 0, 6, 7, 0, 0, 0, 1, 0, 13, 4'b1000, 0);
        repeat (11) @(posedge clk);
        #1;
        reset = 1; alu_op = ALU_ADD;
        q.delete();
        @(posedge clk); #1;
        reset = 0; last_res = 0;
        @(negedge clk);
        checks++;
        if (obs !== '0 || stall_ex !== 1'b0) begin
            errors++;
            $display("FAIL mul_reset_abort got %h stall=%b want 0 stall=0", obs, stall_ex);
        end
    endtask
`else
    task automatic test_mul();
        issue(ALU_MUL, 0, 0, 6, 7, 0, 0, 0, 1, 0, 13, 4'b1000, 0);
        step("mul_disabled");
        issue(ALU_MUL, 0, 0, 32'hFFFF_FFFF, 2, 0, 0, 0, 0, 14, 1, 4'b0001, 0);
        step("mul_disabled_rt");
    endtask
`endif

    task automatic test_back_to_back();
        issue(ALU_ADD, 0, 0, 40, 2, 0, 0, 0, 1, 0, 3, 4'b1000, 0);
        step("b2b_first");
`ifdef EX_MULT_EN
        issue(ALU_MUL, 2'b01, 0, 0, 2, 0, 0, 0, 1, 0, 4, 4'b1000, 0);
        run_mul("b2b_mul1", 0, 33);
        issue(ALU_MUL, 2'b01, 0, 0, 3, 0, 0, 0, 1, 0, 5, 4'b1000, 0);
        run_mul("b2b_mul2", 0, 33);
`else
        issue(ALU_MUL, 2'b01, 0, 0, 2, 0, 0, 0, 1, 0, 4, 4'b1000, 0);
        step("b2b_mul1");
        issue(ALU_MUL, 2'b01, 0, 0, 3, 0, 0, 0, 1, 0, 5, 4'b1000, 0);
        step("b2b_mul2");
`endif
        issue(ALU_ADD, 2'b01, 0, 0, 5, 0, 0, 0, 1, 0, 6, 4'b1000, 0);
        step("b2b_after_mul");
        issue(ALU_SUB, 2'b01, 2'b01, 0, 0, 0, 0, 0, 1, 0, 7, 4'b1000, 0);
        step("b2b_self_sub");
    endtask

    initial begin
        reset = 1; enable = 1; forward_a = 0; forward_b = 0; rs_data = 0; rt_data = 0;
        immediate = 0; write_data = 0; shamt = 0; alu_op = 0; alu_src = 0; reg_dst = 0;
        rt_addr = 0; rd_addr = 0; ctl = 0; last_res = 0;
        test_reset();
        test_add();
        test_forwarding();
        test_ops();
        test_mul();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
